esc_pwm_drv: RTL
================

# esc_pwm_drv

Converts the four 11-bit unsigned motor speeds produced by the flight controller into four hobby-ESC PWM pulse trains. Each output pulse is MIN_PULSE plus three clocks per speed count, repeated every 2^PERIOD_W clocks. New speeds are captured into shadow registers on a strobe and take effect only at a frame boundary, so a pulse is never truncated or stretched mid-frame. After reset the block holds all motors at minimum pulse for an arming interval, then follows commanded speeds.

## Interface
- PERIOD_W, 20: frame counter width; frame = 2^PERIOD_W clocks (20.97 ms @ 50 MHz).
- MIN_PULSE, 50000: pulse length in clocks at speed 0 (1 ms @ 50 MHz).
- ARM_PERIODS, 8: number of complete frames forced to MIN_PULSE after reset.
- Constraint: MIN_PULSE + 3*2047 < 2^PERIOD_W. ARM_PERIODS ≥ 1.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd  in  1  one-cycle strobe; speed inputs valid this cycle
- frnt_spd, bck_spd, lft_spd, rght_spd  in  11 each  unsigned motor speeds
- frnt, bck, lft, rght  out  1 each  registered PWM to ESCs
- armed  out  1  high once RUN state entered
- frame  out  1  registered one-cycle pulse at each frame start

## Operation
- Length arithmetic: len = MIN_PULSE + 3*spd, unsigned, 17 bits wide (PERIOD_W+1 if larger); computed as (spd<<1)+spd, never overflows under the constraint.
- Shadow: on upd, each channel's shadow speed register loads its input. Without upd, shadow holds.
- Active length per channel: loaded only on the wrap edge (cnt == 2^PERIOD_W−1 → 0).
  - ARMING: active ← MIN_PULSE regardless of shadow.
  - RUN: active ← len(shadow). If upd coincides with the wrap edge, the new inputs bypass to active (take effect in the starting frame).
- PWM: each edge, out ← (cnt < active). High for exactly active clocks per frame.
- State machine (2 states):
  - ARMING (reset state): frame counter increments on each wrap edge; on the wrap edge ending frame ARM_PERIODS → RUN, armed ← 1, active loads from shadow (with bypass rule) on that same edge.
  - RUN: terminal until reset.
- upd during ARMING updates shadow; it is used at RUN entry.

## Timing
- Reset values: cnt = 0, active = MIN_PULSE, shadow = 0, out = 0 on all four, armed = 0, frame = 0, state = ARMING, frame counter = 0.
- First frame starts at reset release: first edge sets out = 1; pulse width MIN_PULSE clocks.
- PWM output lags cnt by one cycle; rising edge of every pulse occurs the cycle after cnt = 0.
- frame high for the single cycle while cnt == 0 following a wrap; not asserted for the post-reset frame.
- upd → effect latency: at next wrap edge (0 to 2^PERIOD_W−1 clocks later).
- Multiple upd in one frame: last one wins.
- Speed 0 → MIN_PULSE; speed 0x7FF → MIN_PULSE+6141; no saturation needed.
- Reset asserted mid-pulse: outputs go low immediately (asynchronous), armed drops, arming restarts on release.

## Structure
- Package esc_pkg: SPD_W = 11, SCALE = 3, LEN_W = 17, state enum {ARMING, RUN}, function for len computation.
- Sub-module esc_pwm_chan (instanced 4×): shadow reg, bypass mux, active length reg, comparator, output flop; inputs cnt, wrap, run, upd, spd.
- Top holds counter, wrap detect, frame flop, arming FSM and frame counter.

## Test plan
Bench parameters: PERIOD_W = 14, MIN_PULSE = 100, ARM_PERIODS = 2.
- Reset release, no upd → all four outputs high 100 clocks per 16384-clock frame; armed rises at second wrap edge; frame pulses each wrap.
- upd with frnt = 10, others 0 during ARMING → frnt stays 100 through arming, becomes 130 in first RUN frame; others 100.
- In RUN, upd frnt = 0x7FF mid-frame → current pulse unchanged; next frame pulse 6241 clocks.
- upd asserted exactly on wrap edge with bck = 5 → bck = 115 in the frame that starts on that edge.
- Two upd in one frame (lft = 20 then 40) → next frame lft = 220.
- rst_n low mid-pulse in RUN → all outputs and armed low same cycle; after release, MIN_PULSE arming frames repeat.

Source files
------------

// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared constants, FSM state type and pulse-length helper for esc_pwm_drv
//   SPD_W   : motor speed width
//   SCALE   : clocks added per speed count
//   LEN_W   : minimum pulse-length register width
//   esc_len : MIN_PULSE + SCALE*spd, returned 32 bits wide for the caller to size
package esc_pkg;

  localparam int SPD_W = 11;
  localparam int SCALE = 3;
  localparam int LEN_W = 17;

  typedef enum logic {
    ARMING = 1'b0,
    RUN    = 1'b1
  } esc_state_t;

  // The constant multiply by 3 reduces to (spd << 1) + spd; the result cannot
  // overflow because MIN_PULSE + 3*2047 stays below one frame.
  function automatic logic [31:0] esc_len(input logic [SPD_W-1:0] spd,
                                          input int unsigned      min_pulse);
    logic [31:0] w_spd;
    w_spd = {{(32-SPD_W){1'b0}}, spd};
    return min_pulse + (w_spd * SCALE);
  endfunction

endpackage

// File: rtl/esc_pwm_chan.sv
// rtl/esc_pwm_chan.sv - one ESC PWM channel: shadow speed, frame-aligned active length, output compare
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_cnt          : shared frame position counter
//   i_wrap         : high on the edge where i_cnt wraps to zero
//   i_run          : high when the new frame is a RUN frame (load from speed)
//   i_upd, i_spd   : speed update strobe and value
//   o_pwm          : registered PWM output
module esc_pwm_chan
  import esc_pkg::*;
#(
  parameter int PERIOD_W  = 20,
  parameter int MIN_PULSE = 50000,
  parameter int L_W       = 21
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PERIOD_W-1:0] i_cnt,
  input  logic                i_wrap,
  input  logic                i_run,
  input  logic                i_upd,
  input  logic [SPD_W-1:0]    i_spd,
  output logic                o_pwm
);

  localparam logic [L_W-1:0] MIN_LEN = L_W'(MIN_PULSE);

  logic [SPD_W-1:0] r_shadow;
  logic [L_W-1:0]   r_active;
  logic             r_pwm;

  logic [SPD_W-1:0] w_spd_sel;
  logic [L_W-1:0]   w_len;
  logic [L_W-1:0]   w_cnt_ext;

  // A strobe landing on the wrap edge must reach the frame that starts there,
  // so it bypasses the shadow register.
  assign w_spd_sel = i_upd ? i_spd : r_shadow;
  assign w_len     = L_W'(esc_len(w_spd_sel, MIN_PULSE));
  assign w_cnt_ext = {{(L_W-PERIOD_W){1'b0}}, i_cnt};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_active <= MIN_LEN;
      r_pwm    <= 1'b0;
    end else begin
      if (i_upd) begin
        r_shadow <= i_spd;
      end
      // Length only changes on the frame boundary so a pulse is never cut or stretched.
      if (i_wrap) begin
        r_active <= i_run ? w_len : MIN_LEN;
      end
      r_pwm <= (w_cnt_ext < r_active);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/esc_pwm_drv.sv
// rtl/esc_pwm_drv.sv - four-channel hobby-ESC PWM driver with frame-aligned updates and arming
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_upd                : one-cycle strobe, speed inputs valid
//   i_frnt_spd..i_rght_spd : 11-bit unsigned motor speeds
//   o_frnt..o_rght       : registered PWM outputs
//   o_armed              : high once the RUN state is entered
//   o_frame              : one-cycle pulse at each frame start after a wrap
module esc_pwm_drv
  import esc_pkg::*;
#(
  parameter int PERIOD_W    = 20,
  parameter int MIN_PULSE   = 50000,
  parameter int ARM_PERIODS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_upd,
  input  logic [SPD_W-1:0] i_frnt_spd,
  input  logic [SPD_W-1:0] i_bck_spd,
  input  logic [SPD_W-1:0] i_lft_spd,
  input  logic [SPD_W-1:0] i_rght_spd,
  output logic             o_frnt,
  output logic             o_bck,
  output logic             o_lft,
  output logic             o_rght,
  output logic             o_armed,
  output logic             o_frame
);

  localparam int L_W  = ((PERIOD_W + 1) > LEN_W) ? (PERIOD_W + 1) : LEN_W;
  localparam int FC_W = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;
  localparam logic [FC_W-1:0] LAST_ARM = FC_W'(ARM_PERIODS - 1);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_frame;
  esc_state_t          r_state;
  esc_state_t          w_state_nxt;
  logic [FC_W-1:0]     r_fcnt;
  logic [FC_W-1:0]     w_fcnt_nxt;
  logic                w_wrap;
  logic                w_run;

  logic [SPD_W-1:0]    w_spd [4];
  logic                w_pwm [4];

  assign w_wrap = &r_cnt;
  // Channels need the state of the frame being entered, so the RUN-entry
  // wrap already loads commanded speeds.
  assign w_run  = (w_state_nxt == RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_frame <= 1'b0;
      r_state <= ARMING;
      r_fcnt  <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_frame <= w_wrap;
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ARMING: begin
        if (w_wrap) begin
          if (r_fcnt == LAST_ARM) begin
            w_state_nxt = RUN;
          end else begin
            w_fcnt_nxt = r_fcnt + 1'b1;
          end
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = ARMING;
      end
    endcase
  end

  assign w_spd = '{i_frnt_spd, i_bck_spd, i_lft_spd, i_rght_spd};

  for (genvar g = 0; g < 4; g++) begin : g_chan
    esc_pwm_chan #(
      .PERIOD_W  (PERIOD_W),
      .MIN_PULSE (MIN_PULSE),
      .L_W       (L_W)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_cnt   (r_cnt),
      .i_wrap  (w_wrap),
      .i_run   (w_run),
      .i_upd   (i_upd),
      .i_spd   (w_spd[g]),
      .o_pwm   (w_pwm[g])
    );
  end

  assign o_frnt  = w_pwm[0];
  assign o_bck   = w_pwm[1];
  assign o_lft   = w_pwm[2];
  assign o_rght  = w_pwm[3];
  assign o_armed = (r_state == RUN);
  assign o_frame = r_frame;

endmodule
